// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/response bundle of the iterative multiply/divide unit
// Purpose: groups the execute-stage handshake and operand/result signals.
// Signals:
//   start  : request, taken only when the unit is idle
//   kill   : synchronous abort (pipeline flush)
//   funct3 : RV32M operation select
//   A, B   : rs1 / rs2 operands
//   busy   : unit is not idle (stalls execute)
//   done   : one-cycle completion pulse
//   result : registered result, held until the next done
// Modports: master = execute-stage driver, slave = muldiv_unit.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic            kill;
   logic [2:0]      funct3;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;

   modport master (
      output start, kill, funct3, A, B,
      input  busy, done, result
   );

   modport slave (
      input  start, kill, funct3, A, B,
      output busy, done, result
   );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit
// Purpose: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a 32-iteration
// shift-add multiplier and restoring divider on operand magnitudes.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_unit_if slave (start/kill/funct3/A/B in, busy/done/result out)
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic           clk,
   input  logic           rst_n,
   muldiv_unit_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

   state_t            state_q, state_d;
   logic [4:0]        cnt_q;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   a_q, b_q;      // latched operands, magnitudes after PREP
   logic              neg_a_q, neg_b_q;
   logic [2*XLEN-1:0] prod_q;
   logic [XLEN-1:0]   quo_q, rem_q;
   logic [XLEN-1:0]   result_q;
   logic              done_q;

   // Operand signedness and special-case detection, evaluated in PREP
   logic signed_a, signed_b, neg_a_c, neg_b_c;
   logic b_zero, ovf, special;

   always_comb begin
      signed_a = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
      signed_b = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
      neg_a_c  = signed_a && a_q[XLEN-1];
      neg_b_c  = signed_b && b_q[XLEN-1];
      b_zero   = (b_q == '0);
      // signed overflow only exists for DIV/REM (funct3[0]=0)
      ovf      = !op_q[0] && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
      special  = op_q[2] && (b_zero || ovf);
   end

   // Iteration datapaths
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic              div_fits;

   always_comb begin
      mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, (prod_q[0] ? a_q : '0)};
      // dividend bits are consumed MSB first: bit 31-cnt == bit ~cnt
      div_shift = {rem_q, a_q[~cnt_q]};
      div_fits  = (div_shift >= {1'b0, b_q});
   end

   // Sign correction and output selection for FIX
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, sel_fix;

   always_comb begin
      prod_fix = (neg_a_q ^ neg_b_q) ? -prod_q : prod_q;
      quo_fix  = (neg_a_q ^ neg_b_q) ? -quo_q : quo_q;
      rem_fix  = neg_a_q ? -rem_q : rem_q;
      case (op_q)
         3'b000:                 sel_fix = prod_fix[XLEN-1:0];
         3'b001, 3'b010, 3'b011: sel_fix = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         sel_fix = quo_fix;
         default:                sel_fix = rem_fix;
      endcase
   end

   // Next-state logic; kill overrides every transition and blocks start
   always_comb begin
      state_d = state_q;
      if (bus.kill) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (bus.start) state_d = PREP;
            PREP:    state_d = special ? FIX : RUN;
            RUN:     if (cnt_q == 5'd31) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         prod_q   <= '0;
         quo_q    <= '0;
         rem_q    <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (!bus.kill) begin
            case (state_q)
               IDLE: begin
                  if (bus.start) begin
                     op_q <= bus.funct3;
                     a_q  <= bus.A;
                     b_q  <= bus.B;
                  end
               end
               PREP: begin
                  a_q     <= neg_a_c ? -a_q : a_q;
                  b_q     <= neg_b_c ? -b_q : b_q;
                  // multiplier sits in the low half and shifts out LSB first
                  prod_q  <= {{XLEN{1'b0}}, (neg_b_c ? -b_q : b_q)};
                  cnt_q   <= '0;
                  neg_a_q <= neg_a_c;
                  neg_b_q <= neg_b_c;
                  quo_q   <= '0;
                  rem_q   <= '0;
                  // preset answers bypass sign correction
                  if (special) begin
                     neg_a_q <= 1'b0;
                     neg_b_q <= 1'b0;
                     if (b_zero) begin
                        quo_q <= '1;
                        rem_q <= a_q;
                     end else begin
                        quo_q <= {1'b1, {(XLEN-1){1'b0}}};
                     end
                  end
               end
               RUN: begin
                  cnt_q <= cnt_q + 5'd1;
                  if (!op_q[2]) begin
                     prod_q <= {mul_sum, prod_q[XLEN-1:1]};
                  end else if (div_fits) begin
                     rem_q <= div_shift[XLEN-1:0] - b_q;
                     quo_q <= {quo_q[XLEN-2:0], 1'b1};
                  end else begin
                     rem_q <= div_shift[XLEN-1:0];
                     quo_q <= {quo_q[XLEN-2:0], 1'b0};
                  end
               end
               FIX: begin
                  result_q <= sel_fix;
                  done_q   <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = done_q;
   assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad = 0;
   logic [31:0] last_exp;

   always #5 clk = ~clk;

   muldiv_unit_if #(.XLEN(32)) bus ();
   muldiv_unit #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: RV32M semantics computed with 64-bit integer arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, p;
      logic [31:0] r;
      logic        ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'h0, a};
      ub  = {32'h0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      r   = '0;
      case (f)
         3'd0: begin p = ua * ub; r = p[31:0]; end
         3'd1: begin p = sa * sb; r = p[63:32]; end
         3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
         3'd3: begin p = ua * ub; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (ovf) r = 32'h8000_0000;
            else begin p = sa / sb; r = p[31:0]; end
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (ovf) r = 32'h0;
            else begin p = sa % sb; r = p[31:0]; end
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      return r;
   endfunction

   function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
      return 34;
   endfunction

   task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      bus.start  = 1'b1;
      bus.funct3 = f;
      bus.A      = a;
      bus.B      = b;
   endtask

   // Waits for the accepting edge, then measures latency/busy/result of that request
   task automatic finish(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      int lat = 0;
      int busy_n = 0;
      bit got = 0;
      logic [31:0] exp;
      exp = ref_model(f, a, b);
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.A      = $urandom;
      bus.B      = $urandom;
      bus.funct3 = 3'($urandom);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.busy) busy_n++;
         if (bus.done) begin got = 1; break; end
         lat++;
      end
      check({tag, " done_seen"}, 64'(got), 64'd1);
      check({tag, " latency"}, 64'(lat), 64'(ref_latency(f, a, b)));
      check({tag, " busy_cycles"}, 64'(busy_n), 64'(ref_latency(f, a, b)));
      check({tag, " result"}, 64'(bus.result), 64'(exp));
      last_exp = exp;
   endtask

   task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      launch(f, a, b);
      finish(tag, f, a, b);
   endtask

   initial begin
      int n_done;
      logic [31:0] first_res;
      logic [2:0] f;
      logic [31:0] a, b;
      int mode;

      // reset state
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.kill = 1'b0;
      bus.funct3 = 3'd0;
      bus.A = '0;
      bus.B = '0;
      last_exp = '0;
      #2;
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset result", 64'(bus.result), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // directed operations
      do_op("mul_7x6", 3'd0, 32'd7, 32'd6);
      do_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("mulhu_m1", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2);
      do_op("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2);
      do_op("divu_m7_2", 3'd5, 32'hFFFF_FFF9, 32'd2);
      do_op("remu_m7_2", 3'd7, 32'hFFFF_FFF9, 32'd2);
      do_op("divu_by0", 3'd5, 32'd5, 32'd0);
      do_op("rem_by0", 3'd6, 32'd5, 32'd0);
      do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

      // randomized operations with biased corner operands
      for (int i = 0; i < 40; i++) begin
         f = 3'($urandom_range(0, 7));
         a = $urandom;
         b = $urandom;
         mode = $urandom_range(0, 9);
         if (mode == 0) b = 32'd0;
         else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (mode == 2) b = 32'($urandom_range(1, 15));
         else if (mode == 3) a = 32'($urandom_range(0, 15));
         do_op($sformatf("rand%0d_f%0d", i, f), f, a, b);
      end

      // start during RUN is ignored
      @(negedge clk);
      launch(3'd0, 32'd7, 32'd6);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (10) @(negedge clk);
      launch(3'd0, 32'd100, 32'd100);
      @(posedge clk);
      #1 bus.start = 1'b0;
      n_done = 0;
      first_res = '0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (bus.done) begin
            if (n_done == 0) first_res = bus.result;
            n_done++;
         end
      end
      check("start_in_run done_count", 64'(n_done), 64'd1);
      check("start_in_run result", 64'(first_res), 64'd42);
      last_exp = 32'd42;

      // start in the same cycle as done is accepted
      do_op("b2b_first", 3'd5, 32'd1000, 32'd7);
      check("b2b done_high_at_start", 64'(bus.done), 64'd1);
      launch(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      finish("b2b_second", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);

      // kill at RUN iteration 10
      @(negedge clk);
      launch(3'd5, 32'hDEAD_BEEF, 32'd3);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk);
      check("kill busy_before", 64'(bus.busy), 64'd1);
      bus.kill = 1'b1;
      @(posedge clk);
      #1 bus.kill = 1'b0;
      @(negedge clk);
      check("kill busy_after", 64'(bus.busy), 64'd0);
      n_done = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("kill no_done", 64'(n_done), 64'd0);
      check("kill result_held", 64'(bus.result), 64'(last_exp));

      // asynchronous reset mid-RUN
      do_op("pre_reset_mul", 3'd0, 32'd7, 32'd6);
      @(negedge clk);
      launch(3'd4, 32'h7654_3210, 32'd13);
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (15) @(negedge clk);
      check("rst_mid busy_before", 64'(bus.busy), 64'd1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid busy", 64'(bus.busy), 64'd0);
      check("rst_mid result", 64'(bus.result), 64'd0);
      check("rst_mid done", 64'(bus.done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      check("rst_mid no_done", 64'(n_done), 64'd0);
      do_op("post_reset_rem", 3'd6, 32'hFFFF_FF00, 32'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit for the execute stage. It runs beside the single-cycle ALU: the same decoded operands drive both, and its result is muxed onto the ALU result path when an M-extension instruction completes. It implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a start/busy/done handshake. The pipeline stalls the execute stage while `busy` is high.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; accepted only in IDLE.
- `kill`  in  1  synchronous abort (pipeline flush).
- `funct3`  in  3  encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `A`  in  32  rs1 operand.
- `B`  in  32  rs2 operand.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle completion pulse.
- `result`  out  32  registered result; holds until the next `done`.

## Operation
- States: IDLE, PREP, RUN, FIX.
- **IDLE**
  - `start`=1 latches `A`, `B` and `funct3`, then goes to PREP. Operands may change after this edge.
  - `start`=0 stays in IDLE.
- **PREP**
  - Records the sign of each operand and converts signed operands to magnitudes. Signedness:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: A signed, B unsigned.
    - Others: both operands unsigned.
  - Special cases go directly to FIX with a preset answer:
    - B=0 on DIV/DIVU: quotient = 0xFFFFFFFF.
    - B=0 on REM/REMU: remainder = A.
    - DIV with A=0x80000000 and B=0xFFFFFFFF: quotient = 0x80000000.
    - REM with A=0x80000000 and B=0xFFFFFFFF: remainder = 0.
  - All other cases: clear the 5-bit iteration counter and go to RUN.
- **RUN**
  - Exactly 32 iterations, one per cycle. After the iteration with counter=31, go to FIX.
  - Multiply: radix-2 shift-add on the magnitudes into a 64-bit product register.
  - Divide: restoring division on the magnitudes. The 32-bit quotient and remainder registers both start at 0.
- **FIX**
  - Applies sign correction:
    - Product is negated when the operand signs differ, considering only the operands that are signed.
    - Quotient is negated when the signs differ.
    - Remainder takes the sign of A.
  - Selects the output word:
    - MUL: product[31:0].
    - MULH, MULHSU, MULHU: product[63:32].
    - DIV, DIVU: quotient.
    - REM, REMU: remainder.
  - Writes `result`, pulses `done` and goes to IDLE.
- **Arithmetic:** all results are modulo 2^32. No exceptions or flags are produced.
- **`kill`:** from any non-IDLE state, returns to IDLE on the next edge. No `done` is produced and `result` is unchanged. `kill` has priority over the state transition and over `start`.
- **`start` while busy:** ignored. There is no queuing.
- **`start` with `done` high:** accepted, because the state is already IDLE.

## Timing
- **Reset** (`rst_n`=0, asynchronous):
  - state = IDLE, counter = 0.
  - `busy`=0, `done`=0, `result`=0.
  - All internal operand registers are cleared.
- **Normal latency:** `start` is sampled at edge E0.
  - E1: state enters RUN.
  - E2 through E33: the 32 RUN iterations.
  - E34: leaves FIX.
  - `done`=1 and `result` are valid in the cycle after E34, 34 cycles after acceptance.
- **Special-case latency:** PREP goes to FIX at E1. `done` is high in the cycle after E2.
- **`busy`:** high in the cycle after E0 through the FIX cycle. It is low in the same cycle that `done` is high.
- **`done`:** exactly one cycle wide per accepted, non-killed request.
- **Reset mid-operation:** the operation is lost and no `done` is produced.

## Test plan
- MUL A=7, B=6 -> `done` 34 cycles after the start edge, `result`=42. `busy` high for exactly 34 cycles.
- MULH A=0xFFFFFFFF (-1), B=0xFFFFFFFF -> `result`=0x00000000. The same operands:
  - MULHU -> 0xFFFFFFFE.
  - MULHSU -> 0xFFFFFFFF.
- DIV A=-7 (0xFFFFFFF9), B=2 -> `result`=0xFFFFFFFD (-3). The same operands:
  - REM -> 0xFFFFFFFF (-1).
  - DIVU -> 0x7FFFFFFC.
  - REMU -> 1.
- Special cases, each with `done` 2 cycles after the start edge:
  - DIVU A=5, B=0 -> 0xFFFFFFFF.
  - REM A=5, B=0 -> 5.
  - DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000.
  - REM with the same operands -> 0.
- Handshake:
  - A second `start` pulsed during RUN is ignored, and only one `done` occurs.
  - A `start` in the same cycle as `done` is accepted, and its `done` follows 34 cycles later.
- Abort cases:
  - `kill` at RUN iteration 10 -> IDLE next cycle, no `done`, `result` keeps its previous value.
  - `rst_n` low mid-RUN -> `busy`=0, `result`=0 immediately, without waiting for a clock edge.
